// File: rtl/aec_pkg.sv
// Shared constants, state encoding and error codes for the AEC front-end scheduler.
package aec_pkg;

  localparam int ASCII_W = 8;
  localparam int RES_W   = 7;

  localparam logic [ASCII_W-1:0] EQ     = 8'd61;
  localparam logic [ASCII_W-1:0] LPAREN = 8'd40;
  localparam logic [ASCII_W-1:0] RPAREN = 8'd41;
  localparam logic [ASCII_W-1:0] MUL    = 8'd42;
  localparam logic [ASCII_W-1:0] ADD    = 8'd43;
  localparam logic [ASCII_W-1:0] SUB    = 8'd45;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_OVF = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    WAIT_RES,
    RESP
  } state_t;

endpackage

// File: rtl/aec_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   pick;
  logic           found;

  // Rotate so ptr lands on bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    gnt_dbl = {{N{1'b0}}, pick} << ptr;
    gnt     = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
  end

endmodule

// File: rtl/aec_sched.sv
// Round-robin front end that buffers one requester's expression, replays it gap-free
// into the shared AEC core and returns the tagged result.
module aec_sched
  import aec_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  input  logic [N_REQ-1:0]         in_valid,
  input  logic [8*N_REQ-1:0]       in_data,
  output logic                     in_ready,
  output logic                     aec_ready,
  output logic [ASCII_W-1:0]       aec_ascii,
  input  logic                     aec_valid,
  input  logic [RES_W-1:0]         aec_result,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [RES_W-1:0]         resp_result,
  output logic [1:0]               resp_err,
  output logic                     busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = IDX_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t             state;
  state_t             state_next;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    arb_idx;
  logic [ID_W-1:0]    next_ptr;
  logic [N_REQ-1:0]   arb_gnt;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   cnt;
  logic [TMR_W-1:0]   timer;
  logic [ASCII_W-1:0] buffer [MAX_LEN];
  logic [ASCII_W-1:0] cur_char;
  logic               cur_req;
  logic               cur_valid;
  logic               accept;
  logic               load_abort;
  logic               load_eq;
  logic               load_full;
  logic               feed_last;
  logic               res_hit;
  logic               res_timeout;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  // resp_id doubles as the granted index for the whole transaction.
  always_comb begin
    arb_idx   = '0;
    cur_char  = '0;
    cur_req   = 1'b0;
    cur_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = ID_W'(i);
      if (resp_id == ID_W'(i)) begin
        cur_char  = in_data[i*ASCII_W +: ASCII_W];
        cur_req   = req[i];
        cur_valid = in_valid[i];
      end
    end
  end

  assign next_ptr    = (resp_id == ID_W'(N_REQ - 1)) ? '0 : resp_id + 1'b1;
  assign load_abort  = (state == LOAD) && !cur_req;
  assign accept      = (state == LOAD) && cur_req && cur_valid;
  assign load_eq     = accept && (cur_char == EQ);
  assign load_full   = accept && (cur_char != EQ) && (len == LEN_W'(MAX_LEN - 1));
  assign feed_last   = (state == FEED) && (cnt + 1'b1 == len);
  assign res_hit     = (state == WAIT_RES) && aec_valid;
  // Fires in the TIMEOUT-th wait cycle; a result in that same cycle still wins.
  assign res_timeout = (state == WAIT_RES) && !aec_valid && (timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    aec_ready  = 1'b0;
    aec_ascii  = '0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (|req) state_next = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (load_abort)     state_next = IDLE;
        else if (load_eq)   state_next = FEED;
        else if (load_full) state_next = RESP;
      end
      FEED: begin
        aec_ascii = buffer[cnt[IDX_W-1:0]];
        aec_ready = (cnt == '0);
        if (feed_last) state_next = WAIT_RES;
      end
      WAIT_RES: if (res_hit || res_timeout) state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) buffer[len[IDX_W-1:0]] <= cur_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt         <= '0;
      resp_id     <= '0;
      rr_ptr      <= '0;
      len         <= '0;
      cnt         <= '0;
      timer       <= '0;
      resp_result <= '0;
      resp_err    <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt         <= arb_gnt;
            resp_id     <= arb_idx;
            len         <= '0;
            cnt         <= '0;
            resp_result <= '0;
            resp_err    <= ERR_OK;
          end
        end
        LOAD: begin
          if (load_abort) begin
            rr_ptr <= next_ptr;
            gnt    <= '0;
          end else if (accept) begin
            len <= len + 1'b1;
            if (load_full) begin
              resp_err    <= ERR_OVF;
              resp_result <= '0;
            end
          end
        end
        FEED: begin
          cnt <= cnt + 1'b1;
          if (feed_last) timer <= '0;
        end
        WAIT_RES: begin
          if (res_hit) begin
            resp_result <= aec_result;
            resp_err    <= ERR_OK;
          end else if (res_timeout) begin
            resp_result <= '0;
            resp_err    <= ERR_TMO;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            rr_ptr <= next_ptr;
            gnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aec_sched.sv
// Directed bench for aec_sched: a small AEC stub answers fed expressions with a
// programmable latency and result; each test task checks its own expectations.
module tb_aec_sched;
  import aec_pkg::*;

  localparam int N_REQ   = 4;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 255;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_REQ-1:0]   req = '0;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   in_valid = '0;
  logic [8*N_REQ-1:0] in_data = '0;
  logic               in_ready;
  logic               aec_ready;
  logic [7:0]         aec_ascii;
  logic               aec_valid = 1'b0;
  logic [6:0]         aec_result = '0;
  logic               resp_valid;
  logic               resp_ready = 1'b0;
  logic [1:0]         resp_id;
  logic [6:0]         resp_result;
  logic [1:0]         resp_err;
  logic               busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic       stub_on = 1'b1;
  int         stub_lat = 2;
  logic [6:0] stub_res = '0;
  logic       force_valid = 1'b0;
  logic       stub_pulse;
  int         cd = 0;
  string      fed = "";
  int         ready_cnt = 0;
  int         ready_cyc = 0;
  int         eq_cyc = 0;

  aec_sched #(.N_REQ(N_REQ), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .aec_ready   (aec_ready),
    .aec_ascii   (aec_ascii),
    .aec_valid   (aec_valid),
    .aec_result  (aec_result),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // AEC stub: records the fed stream and pulses aec_valid stub_lat cycles after '='.
  always @(negedge clk) begin
    stub_pulse = 1'b0;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) stub_pulse = 1'b1;
    end
    if (aec_ready) begin
      fed = "";
      ready_cnt = ready_cnt + 1;
      ready_cyc = cyc;
    end
    if (aec_ascii != 8'd0) fed = $sformatf("%s%c", fed, aec_ascii);
    if (aec_ascii == EQ) begin
      eq_cyc = cyc;
      if (stub_on) cd = stub_lat;
    end
    aec_valid  = stub_pulse | force_valid;
    aec_result = stub_pulse ? stub_res : 7'd0;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_char(input int id, input logic [7:0] c, input logic v);
    in_valid = '0;
    in_data  = '0;
    if (v) begin
      in_valid[id]       = 1'b1;
      in_data[id*8 +: 8] = c;
    end
  endtask

  task automatic drive_expr(input int id, input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      for (int g = 0; g < gap; g++) begin
        set_char(id, 8'd0, 1'b0);
        tick();
      end
      set_char(id, s[i], 1'b1);
      tick();
    end
    set_char(id, 8'd0, 1'b0);
  endtask

  task automatic wait_resp(input int budget, output int n);
    n = 0;
    while (!resp_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_gnt(input int budget);
    int n;
    n = 0;
    while (gnt == '0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if ({gnt, in_ready, aec_ready, aec_ascii, resp_valid, resp_id, resp_result, resp_err, busy} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got gnt=%b in_ready=%b aec_ready=%b ascii=%h rv=%b id=%0d res=%0d err=%0d busy=%b, expected all zero",
               gnt, in_ready, aec_ready, aec_ascii, resp_valid, resp_id, resp_result, resp_err, busy);
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({busy, gnt} !== '0) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: got busy=%b gnt=%b, expected 0/0000", busy, gnt);
    end
  endtask

  task automatic test_single_expr();
    int start, r0, n;
    stub_on  = 1'b1;
    stub_lat = 3;
    stub_res = 7'd11;
    r0    = ready_cnt;
    start = cyc;
    req   = 4'b0001;
    tick();
    tests++;
    if ({gnt, in_ready, busy} !== {4'b0001, 1'b1, 1'b1}) begin
      fails++;
      $display("[TB] FAIL single_grant: got gnt=%b in_ready=%b busy=%b, expected 0001/1/1", gnt, in_ready, busy);
    end
    drive_expr(0, "3+4*2=", 0);
    tests++;
    if ({aec_ready, in_ready, aec_ascii} !== {1'b1, 1'b0, 8'd51}) begin
      fails++;
      $display("[TB] FAIL single_feed_start: got aec_ready=%b in_ready=%b ascii=%h, expected 1/0/33", aec_ready, in_ready, aec_ascii);
    end
    wait_resp(50, n);
    // 1 grant + 6 load + 6 feed + 3 stub cycles
    tests++;
    if (!resp_valid || (cyc - start) != 16) begin
      fails++;
      $display("[TB] FAIL single_latency: got resp_valid=%b after %0d cycles, expected 1 after 16", resp_valid, cyc - start);
    end
    tests++;
    if (fed != "3+4*2=" || (ready_cnt - r0) != 1) begin
      fails++;
      $display("[TB] FAIL single_stream: got '%s' with %0d starts, expected '3+4*2=' with 1", fed, ready_cnt - r0);
    end
    tests++;
    if ({resp_id, resp_result, resp_err} !== {2'd0, 7'd11, ERR_OK}) begin
      fails++;
      $display("[TB] FAIL single_resp: got id=%0d res=%0d err=%0d, expected 0/11/0", resp_id, resp_result, resp_err);
    end
    req = '0;
    ack();
    tests++;
    if ({resp_valid, busy, gnt} !== '0) begin
      fails++;
      $display("[TB] FAIL single_release: got rv=%b busy=%b gnt=%b, expected 0/0/0000", resp_valid, busy, gnt);
    end
  endtask

  task automatic test_round_robin();
    int exp_ids[4] = '{0, 1, 3, 0};
    int n;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    req = 4'b1011;
    stub_lat = 2;
    for (int k = 0; k < 4; k++) begin
      stub_res = 7'(20 + k);
      wait_gnt(10);
      tests++;
      if (gnt !== 4'(1 << exp_ids[k])) begin
        fails++;
        $display("[TB] FAIL rr_grant_%0d: got gnt=%b, expected requester %0d", k, gnt, exp_ids[k]);
      end
      drive_expr(exp_ids[k], "1+1=", 0);
      wait_resp(50, n);
      tests++;
      if ({resp_valid, resp_id, resp_result, resp_err} !== {1'b1, 2'(exp_ids[k]), 7'(20 + k), ERR_OK}) begin
        fails++;
        $display("[TB] FAIL rr_resp_%0d: got rv=%b id=%0d res=%0d err=%0d, expected 1/%0d/%0d/0",
                 k, resp_valid, resp_id, resp_result, resp_err, exp_ids[k], 20 + k);
      end
      ack();
    end
    req = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    req = 4'b0011;
    resp_ready = 1'b1;
    stub_lat = 1;
    stub_res = 7'd5;
    wait_gnt(10);
    tests++;
    if (gnt !== 4'b0010) begin
      fails++;
      $display("[TB] FAIL b2b_first_grant: got gnt=%b, expected 0010", gnt);
    end
    drive_expr(1, "8=", 0);
    wait_resp(50, n);
    tests++;
    if ({resp_valid, resp_id, resp_result} !== {1'b1, 2'd1, 7'd5}) begin
      fails++;
      $display("[TB] FAIL b2b_resp: got rv=%b id=%0d res=%0d, expected 1/1/5", resp_valid, resp_id, resp_result);
    end
    tick();
    tests++;
    if ({resp_valid, gnt} !== '0) begin
      fails++;
      $display("[TB] FAIL b2b_one_cycle_resp: got rv=%b gnt=%b, expected 0/0000", resp_valid, gnt);
    end
    tick();
    tests++;
    if (gnt !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL b2b_next_grant: got gnt=%b, expected 0001", gnt);
    end
    stub_res = 7'd6;
    drive_expr(0, "8=", 0);
    wait_resp(50, n);
    tests++;
    if ({resp_valid, resp_id, resp_result} !== {1'b1, 2'd0, 7'd6}) begin
      fails++;
      $display("[TB] FAIL b2b_second_resp: got rv=%b id=%0d res=%0d, expected 1/0/6", resp_valid, resp_id, resp_result);
    end
    req = '0;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int r0;
    r0  = ready_cnt;
    req = 4'b0100;
    tick();
    drive_expr(2, "1234567890123456", 0);
    tests++;
    if ({resp_valid, resp_id, resp_err, resp_result} !== {1'b1, 2'd2, ERR_OVF, 7'd0}) begin
      fails++;
      $display("[TB] FAIL overflow_resp: got rv=%b id=%0d err=%0d res=%0d, expected 1/2/1/0", resp_valid, resp_id, resp_err, resp_result);
    end
    tests++;
    if ((ready_cnt - r0) != 0 || aec_ascii !== 8'd0) begin
      fails++;
      $display("[TB] FAIL overflow_no_start: got %0d starts ascii=%h, expected 0 starts ascii=00", ready_cnt - r0, aec_ascii);
    end
    req = '0;
    ack();
  endtask

  task automatic test_abort();
    req = 4'b0010;
    tick();
    tests++;
    if (gnt !== 4'b0010) begin
      fails++;
      $display("[TB] FAIL abort_grant: got gnt=%b, expected 0010", gnt);
    end
    drive_expr(1, "1+", 0);
    req = '0;
    tick();
    tests++;
    if ({busy, resp_valid, gnt} !== '0) begin
      fails++;
      $display("[TB] FAIL abort_silent: got busy=%b rv=%b gnt=%b, expected 0/0/0000", busy, resp_valid, gnt);
    end
    req = 4'b0110;
    tick();
    tests++;
    if (gnt !== 4'b0100) begin
      fails++;
      $display("[TB] FAIL abort_ptr_advance: got gnt=%b, expected 0100", gnt);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int n;
    logic bad;
    stub_on = 1'b0;
    req = 4'b1000;
    tick();
    drive_expr(3, "9=", 0);
    wait_resp(400, n);
    tests++;
    if ({resp_valid, resp_id, resp_err, resp_result} !== {1'b1, 2'd3, ERR_TMO, 7'd0}) begin
      fails++;
      $display("[TB] FAIL timeout_resp: got rv=%b id=%0d err=%0d res=%0d, expected 1/3/2/0", resp_valid, resp_id, resp_err, resp_result);
    end
    // TIMEOUT wait cycles follow the '=' cycle, then RESP is visible.
    tests++;
    if ((cyc - eq_cyc) != TIMEOUT + 1) begin
      fails++;
      $display("[TB] FAIL timeout_cycles: got %0d cycles from '=' to response, expected %0d", cyc - eq_cyc, TIMEOUT + 1);
    end
    req = '0;
    ack();
    force_valid = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (busy || resp_valid) bad = 1'b1;
    end
    force_valid = 1'b0;
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_ignores_valid: got busy/resp activity=%b, expected 0", bad);
    end
    tick();
    stub_on = 1'b1;
  endtask

  task automatic test_timeout_edge();
    int n;
    stub_lat = TIMEOUT;
    stub_res = 7'd42;
    req = 4'b1000;
    tick();
    drive_expr(3, "9=", 0);
    wait_resp(400, n);
    tests++;
    if ({resp_valid, resp_err, resp_result} !== {1'b1, ERR_OK, 7'd42}) begin
      fails++;
      $display("[TB] FAIL timeout_edge_resp: got rv=%b err=%0d res=%0d, expected 1/0/42", resp_valid, resp_err, resp_result);
    end
    tests++;
    if ((cyc - eq_cyc) != TIMEOUT + 1) begin
      fails++;
      $display("[TB] FAIL timeout_edge_cycles: got %0d, expected %0d", cyc - eq_cyc, TIMEOUT + 1);
    end
    req = '0;
    ack();
  endtask

  task automatic test_gaps_backpressure();
    int n;
    logic bad;
    stub_lat = 2;
    stub_res = 7'd9;
    req = 4'b0010;
    tick();
    drive_expr(1, "7-2*3=", 3);
    wait_resp(100, n);
    tests++;
    if (fed != "7-2*3=" || (eq_cyc - ready_cyc) != 5) begin
      fails++;
      $display("[TB] FAIL gaps_feed: got '%s' spanning %0d cycles, expected '7-2*3=' spanning 5", fed, eq_cyc - ready_cyc);
    end
    tests++;
    if ({resp_valid, resp_id, resp_result, resp_err} !== {1'b1, 2'd1, 7'd9, ERR_OK}) begin
      fails++;
      $display("[TB] FAIL gaps_resp: got rv=%b id=%0d res=%0d err=%0d, expected 1/1/9/0", resp_valid, resp_id, resp_result, resp_err);
    end
    bad = 1'b0;
    repeat (5) begin
      tick();
      if ({resp_valid, resp_id, resp_result, resp_err} !== {1'b1, 2'd1, 7'd9, ERR_OK}) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("[TB] FAIL backpressure_stable: got unstable=%b, expected 0", bad);
    end
    req = '0;
    ack();
    tests++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL backpressure_release: got rv=%b, expected 0", resp_valid);
    end
  endtask

  task automatic test_reset_mid_feed();
    int n;
    logic bad;
    stub_lat = 1;
    stub_res = 7'd3;
    req = 4'b0001;
    tick();
    drive_expr(0, "1=", 0);
    wait_resp(50, n);
    req = '0;
    ack();
    req = 4'b0100;
    tick();
    drive_expr(2, "5*5=", 0);
    tests++;
    if (aec_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_feed_entry: got aec_ready=%b, expected 1", aec_ready);
    end
    rst = 1'b1;
    tick();
    tests++;
    if ({gnt, in_ready, aec_ready, aec_ascii, resp_valid, resp_id, resp_result, resp_err, busy} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid_feed: got gnt=%b aec_ready=%b ascii=%h rv=%b id=%0d busy=%b, expected all zero",
               gnt, aec_ready, aec_ascii, resp_valid, resp_id, busy);
    end
    rst = 1'b0;
    req = '0;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (resp_valid || busy) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_no_response: got activity=%b, expected 0", bad);
    end
    req = 4'b0101;
    tick();
    tests++;
    if (gnt !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL reset_ptr: got gnt=%b, expected 0001", gnt);
    end
    req = '0;
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, expected the run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_expr();
    test_round_robin();
    test_back_to_back();
    test_overflow();
    test_abort();
    test_timeout();
    test_timeout_edge();
    test_gaps_backpressure();
    test_reset_mid_feed();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
